// File: rtl/morse_tx_engine.sv
// Morse/serial pattern transmitter: shifts a left-aligned on/off pattern out MSB-first,
// one symbol per DIV clocks, with start/busy/done handshake, abort and auto-repeat.
module morse_tx_engine #(
  parameter int PAT_W   = 14,
  parameter int DIV     = 25_000_000,
  parameter int GAP_SYM = 3,
  parameter int LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int TMR_W = $clog2(DIV);
  localparam int GAP_W = $clog2(GAP_SYM + 1);

  localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(DIV - 1);
  localparam logic [LEN_W-1:0] LEN_ZERO   = LEN_W'(0);
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(PAT_W);
  localparam logic [GAP_W-1:0] GAP_ZERO   = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_SYM);
  localparam logic [PAT_W-1:0] PAT_ZERO   = PAT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // A requested length beyond the register width sends the whole register.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] req_len);
    if (req_len > LEN_MAX) begin
      clamp_len = LEN_MAX;
    end else begin
      clamp_len = req_len;
    end
  endfunction

  state_t             state_r,   state_s;
  logic [TMR_W-1:0]   timer_r,   timer_s;
  logic [PAT_W-1:0]   shift_r,   shift_s;
  logic [PAT_W-1:0]   pat_r,     pat_s;
  logic [LEN_W-1:0]   len_r,     len_s;
  logic               rep_r,     rep_s;
  logic [LEN_W-1:0]   sym_cnt_r, sym_cnt_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic               out_r,     out_s;
  logic               busy_r,    busy_s;
  logic               done_r,    done_s;
  logic               tick_s;

  // Next-state, datapath and output decode for the IDLE/SEND/GAP machine.
  always_comb begin
    state_s   = state_r;
    timer_s   = timer_r;
    shift_s   = shift_r;
    pat_s     = pat_r;
    len_s     = len_r;
    rep_s     = rep_r;
    sym_cnt_s = sym_cnt_r;
    gap_cnt_s = gap_cnt_r;
    done_s    = 1'b0;
    tick_s    = (timer_r == TMR_ZERO);

    if (abort) begin
      state_s = ST_IDLE;
      timer_s = TMR_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && (len != LEN_ZERO)) begin
            pat_s     = pattern;
            len_s     = clamp_len(len);
            rep_s     = repeat_en;
            shift_s   = pattern;
            sym_cnt_s = clamp_len(len);
            timer_s   = TMR_RELOAD;
            state_s   = ST_SEND;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_SEND: begin
          if (tick_s) begin
            timer_s   = TMR_RELOAD;
            shift_s   = {shift_r[PAT_W-2:0], 1'b0};
            sym_cnt_s = sym_cnt_r - LEN_ONE;
            if (sym_cnt_r == LEN_ONE) begin
              if (rep_r) begin
                gap_cnt_s = GAP_RELOAD;
                state_s   = ST_GAP;
              end else begin
                timer_s = TMR_ZERO;
                done_s  = 1'b1;
                state_s = ST_IDLE;
              end
            end else begin
              state_s = ST_SEND;
            end
          end else begin
            timer_s = timer_r - TMR_ONE;
          end
        end
        ST_GAP: begin
          if (tick_s) begin
            timer_s   = TMR_RELOAD;
            gap_cnt_s = gap_cnt_r - GAP_ONE;
            if (gap_cnt_r == GAP_ONE) begin
              shift_s   = pat_r;
              sym_cnt_s = len_r;
              state_s   = ST_SEND;
            end else begin
              state_s = ST_GAP;
            end
          end else begin
            timer_s = timer_r - TMR_ONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          timer_s = TMR_ZERO;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    if (state_s == ST_SEND) begin
      out_s = shift_s[PAT_W-1];
    end else begin
      out_s = 1'b0;
    end
    if (state_s != ST_IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      timer_r   <= TMR_ZERO;
      shift_r   <= PAT_ZERO;
      pat_r     <= PAT_ZERO;
      len_r     <= LEN_ZERO;
      rep_r     <= 1'b0;
      sym_cnt_r <= LEN_ZERO;
      gap_cnt_r <= GAP_ZERO;
      out_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      timer_r   <= timer_s;
      shift_r   <= shift_s;
      pat_r     <= pat_s;
      len_r     <= len_s;
      rep_r     <= rep_s;
      sym_cnt_r <= sym_cnt_s;
      gap_cnt_r <= gap_cnt_s;
      out_r     <= out_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign out  = out_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
